// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams byte pairs from a serial source into instruction memory words.
module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);
  localparam logic [2:0] IDLE = 3'd0, LOAD_HI = 3'd1, LOAD_LO = 3'd2, WRITE = 3'd3, DONE = 3'd4;
  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [7:0]        hi;
  logic              xfer;
  logic [ADDR_W:0]   next_ww;
  assign rx_ready = (state == LOAD_HI) || (state == LOAD_LO);
  assign mem_we   = state == WRITE;
  assign busy     = rx_ready || mem_we;
  assign done     = state == DONE;
  assign xfer     = rx_valid && rx_ready;
  assign next_ww  = words_written + 1'b1;
  // mem_addr/mem_wdata are registered when the low byte lands so they hold after WRITE
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      count         <= '0;
      hi            <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          words_written <= '0;
          if (word_count != '0) begin
            addr  <= base_addr;
            count <= word_count;
            state <= LOAD_HI;
          end else state <= DONE;
        end
        LOAD_HI: if (xfer) begin
          hi    <= rx_data;
          state <= LOAD_LO;
        end
        LOAD_LO: if (xfer) begin
          mem_addr  <= addr;
          mem_wdata <= DATA_W'({hi, rx_data});
          state     <= WRITE;
        end
        WRITE: begin
          addr          <= addr + 1'b1;
          words_written <= next_ww;
          state         <= (next_ww == count) ? DONE : LOAD_HI;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: per-cycle directed vectors plus a stalled-load sequence for instr_mem_loader.
module tb_instr_mem_loader;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 0;
  logic        rx_ready, mem_we, busy, done;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [10:0] words_written;
  int tests = 0;
  int fails = 0;

  instr_mem_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        st;
    logic [9:0]  base;
    logic [10:0] cnt;
    logic [7:0]  d;
    logic        v;
    logic [3:0]  flags;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [10:0] ww;
  } vec_t;
  vec_t vecs[$];

  // flags = {rx_ready, mem_we, busy, done}
  localparam logic [3:0] F_IDLE = 4'b0000, F_LOAD = 4'b1010, F_WR = 4'b0110, F_DONE = 4'b0001;

  task automatic add(input string n, input logic r, input logic s, input logic [9:0] b,
                     input logic [10:0] c, input logic [7:0] d, input logic v, input logic [3:0] f,
                     input logic [9:0] a, input logic [15:0] w, input logic [10:0] ww);
    vec_t t;
    t.name = n; t.rst = r; t.st = s; t.base = b; t.cnt = c; t.d = d; t.v = v;
    t.flags = f; t.addr = a; t.wdata = w; t.ww = ww;
    vecs.push_back(t);
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  initial begin
    // base load, garbage byte offered during WRITE must be ignored
    add("base0", 0, 1, 0, 3, 8'h00, 0, F_IDLE, 0, 16'h0000, 0);
    add("base1", 0, 0, 0, 0, 8'h4C, 1, F_LOAD, 0, 16'h0000, 0);
    add("base2", 0, 0, 0, 0, 8'h06, 1, F_LOAD, 0, 16'h0000, 0);
    add("base3", 0, 0, 0, 0, 8'hFF, 1, F_WR,   0, 16'h4C06, 0);
    add("base4", 0, 0, 0, 0, 8'h44, 1, F_LOAD, 0, 16'h4C06, 1);
    add("base5", 0, 0, 0, 0, 8'h84, 1, F_LOAD, 0, 16'h4C06, 1);
    add("base6", 0, 0, 0, 0, 8'hFF, 1, F_WR,   1, 16'h4484, 1);
    add("base7", 0, 0, 0, 0, 8'h00, 1, F_LOAD, 1, 16'h4484, 2);
    add("base8", 0, 0, 0, 0, 8'h83, 1, F_LOAD, 1, 16'h4484, 2);
    add("base9", 0, 0, 0, 0, 8'hFF, 1, F_WR,   2, 16'h0083, 2);
    add("baseA", 0, 0, 0, 0, 8'hFF, 1, F_DONE, 2, 16'h0083, 3);
    add("baseB", 0, 0, 0, 0, 8'hFF, 1, F_IDLE, 2, 16'h0083, 3);
    // address wrap 1023 -> 0
    add("wrap0", 0, 1, 1023, 2, 8'h00, 0, F_IDLE, 2, 16'h0083, 3);
    add("wrap1", 0, 0, 0, 0, 8'h12, 1, F_LOAD, 2,    16'h0083, 0);
    add("wrap2", 0, 0, 0, 0, 8'h34, 1, F_LOAD, 2,    16'h0083, 0);
    add("wrap3", 0, 0, 0, 0, 8'h00, 0, F_WR,   1023, 16'h1234, 0);
    add("wrap4", 0, 0, 0, 0, 8'h56, 1, F_LOAD, 1023, 16'h1234, 1);
    add("wrap5", 0, 0, 0, 0, 8'h78, 1, F_LOAD, 1023, 16'h1234, 1);
    add("wrap6", 0, 0, 0, 0, 8'h00, 0, F_WR,   0,    16'h5678, 1);
    add("wrap7", 0, 0, 0, 0, 8'h00, 0, F_DONE, 0,    16'h5678, 2);
    add("wrap8", 0, 0, 0, 0, 8'h00, 0, F_IDLE, 0,    16'h5678, 2);
    // zero count: straight to DONE, no write, never busy
    add("zero0", 0, 1, 5, 0, 8'h00, 0, F_IDLE, 0, 16'h5678, 2);
    add("zero1", 0, 0, 0, 0, 8'h00, 0, F_DONE, 0, 16'h5678, 0);
    add("zero2", 0, 0, 0, 0, 8'h00, 0, F_IDLE, 0, 16'h5678, 0);
    // rx_valid alternating 1/0; idle-cycle bytes are junk
    add("bp0", 0, 1, 10, 2, 8'h00, 0, F_IDLE, 0,  16'h5678, 0);
    add("bp1", 0, 0, 0, 0, 8'hAB, 1, F_LOAD, 0,  16'h5678, 0);
    add("bp2", 0, 0, 0, 0, 8'h99, 0, F_LOAD, 0,  16'h5678, 0);
    add("bp3", 0, 0, 0, 0, 8'hCD, 1, F_LOAD, 0,  16'h5678, 0);
    add("bp4", 0, 0, 0, 0, 8'h99, 0, F_WR,   10, 16'hABCD, 0);
    add("bp5", 0, 0, 0, 0, 8'hEF, 1, F_LOAD, 10, 16'hABCD, 1);
    add("bp6", 0, 0, 0, 0, 8'h99, 0, F_LOAD, 10, 16'hABCD, 1);
    add("bp7", 0, 0, 0, 0, 8'h01, 1, F_LOAD, 10, 16'hABCD, 1);
    add("bp8", 0, 0, 0, 0, 8'h99, 0, F_WR,   11, 16'hEF01, 1);
    add("bp9", 0, 0, 0, 0, 8'h99, 1, F_DONE, 11, 16'hEF01, 2);
    add("bpA", 0, 0, 0, 0, 8'h99, 0, F_IDLE, 11, 16'hEF01, 2);
    // start re-pulsed in LOAD_LO with different base/count
    add("ign0", 0, 1, 20, 2,  8'h00, 0, F_IDLE, 11, 16'hEF01, 2);
    add("ign1", 0, 0, 0, 0,   8'h11, 1, F_LOAD, 11, 16'hEF01, 0);
    add("ign2", 0, 1, 100, 5, 8'h22, 1, F_LOAD, 11, 16'hEF01, 0);
    add("ign3", 0, 0, 0, 0,   8'h00, 0, F_WR,   20, 16'h1122, 0);
    add("ign4", 0, 0, 0, 0,   8'h33, 1, F_LOAD, 20, 16'h1122, 1);
    add("ign5", 0, 0, 0, 0,   8'h44, 1, F_LOAD, 20, 16'h1122, 1);
    add("ign6", 0, 0, 0, 0,   8'h00, 0, F_WR,   21, 16'h3344, 1);
    add("ign7", 0, 0, 0, 0,   8'h00, 0, F_DONE, 21, 16'h3344, 2);
    add("ign8", 0, 0, 0, 0,   8'h00, 0, F_IDLE, 21, 16'h3344, 2);
    // reset in LOAD_LO of word 2 with a valid byte pending, then a clean reload
    add("rst0", 0, 1, 40, 4, 8'h00, 0, F_IDLE, 21, 16'h3344, 2);
    add("rst1", 0, 0, 0, 0,  8'hA1, 1, F_LOAD, 21, 16'h3344, 0);
    add("rst2", 0, 0, 0, 0,  8'hB2, 1, F_LOAD, 21, 16'h3344, 0);
    add("rst3", 0, 0, 0, 0,  8'h00, 0, F_WR,   40, 16'hA1B2, 0);
    add("rst4", 0, 0, 0, 0,  8'hC3, 1, F_LOAD, 40, 16'hA1B2, 1);
    add("rst5", 1, 1, 9, 3,  8'hD4, 1, F_LOAD, 40, 16'hA1B2, 1);
    add("rst6", 0, 0, 0, 0,  8'hE5, 1, F_IDLE, 0,  16'h0000, 0);
    add("rst7", 0, 1, 50, 1, 8'h00, 0, F_IDLE, 0,  16'h0000, 0);
    add("rst8", 0, 0, 0, 0,  8'h5A, 1, F_LOAD, 0,  16'h0000, 0);
    add("rst9", 0, 0, 0, 0,  8'hA5, 1, F_LOAD, 0,  16'h0000, 0);
    add("rstA", 0, 0, 0, 0,  8'h00, 0, F_WR,   50, 16'h5AA5, 0);
    add("rstB", 0, 0, 0, 0,  8'h00, 0, F_DONE, 50, 16'h5AA5, 1);
    add("rstC", 0, 0, 0, 0,  8'h00, 0, F_IDLE, 50, 16'h5AA5, 1);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      reset = vecs[i].rst; start = vecs[i].st; base_addr = vecs[i].base;
      word_count = vecs[i].cnt; rx_data = vecs[i].d; rx_valid = vecs[i].v;
      @(negedge clk);
      chk(vecs[i].name, 64'({rx_ready, mem_we, busy, done, mem_addr, mem_wdata, words_written}),
          64'({vecs[i].flags, vecs[i].addr, vecs[i].wdata, vecs[i].ww}));
      @(posedge clk);
    end

    // long stall in LOAD_HI with start pulses that must be ignored
    #1; start = 1; base_addr = 7; word_count = 1; rx_valid = 0;
    @(posedge clk); #1; start = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hi", 64'({rx_ready, busy, mem_we}), 64'(3'b110));
      @(posedge clk); #1; start = k[0]; base_addr = 900; word_count = 9;
    end
    start = 0; rx_valid = 1; rx_data = 8'h77;
    @(posedge clk); #1; rx_data = 8'h88;
    @(posedge clk); #1; rx_valid = 0;
    begin
      int writes = 0;
      logic seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        if (mem_we) begin
          writes++;
          chk("stall_wr", 64'({mem_addr, mem_wdata}), 64'({10'd7, 16'h7788}));
        end
        seen = done;
      end
      chk("stall_done", 64'(seen), 64'(1));
      chk("stall_writes", 64'(writes), 64'(1));
      chk("stall_ww", 64'(words_written), 64'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
